// File: rtl/bm_divide_pkg.sv
// Shared definitions for the bm_base_divide restoring divider.
// Holds the default widths, the FSM encoding and the iteration-counter width helper.
package bm_divide_pkg;

    localparam int DEF_BITS = 8;
    localparam int DEF_B2TS = 2 * DEF_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int iterations);
        return (iterations <= 2) ? 1 : $clog2(iterations);
    endfunction

    localparam int CNT_W = cnt_width(DEF_B2TS);

endpackage

// File: rtl/bm_base_divide_if.sv
// Request/result bundle for bm_base_divide; master issues operands, slave returns results.
interface bm_base_divide_if
    import bm_divide_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int B2TS = DEF_B2TS
) ();

    logic            start;
    logic [B2TS-1:0] dividend_in;
    logic [BITS-1:0] divisor_in;
    logic            busy;
    logic            valid;
    logic [B2TS-1:0] quot_out;
    logic [BITS-1:0] rem_out;
    logic            div_zero;

    modport master (
        output start, dividend_in, divisor_in,
        input  busy, valid, quot_out, rem_out, div_zero
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output busy, valid, quot_out, rem_out, div_zero
    );

endinterface

// File: rtl/bm_divide_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module bm_divide_step #(
    parameter int BITS = 8
) (
    input  logic [BITS:0]   prem_in,
    input  logic            bit_in,
    input  logic [BITS-1:0] divisor,
    output logic [BITS:0]   prem_out,
    output logic            q_bit
);

    logic [BITS+1:0] shifted;
    logic [BITS:0]   diff;

    always_comb begin
        shifted  = {prem_in, bit_in};
        q_bit    = (shifted >= {2'b00, divisor});
        // When the subtract succeeds the difference is below the divisor, so BITS+1 bits suffice.
        diff     = shifted[BITS:0] - {1'b0, divisor};
        prem_out = q_bit ? diff : shifted[BITS:0];
    end

endmodule

// File: rtl/bm_base_divide.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Define BM_DIVIDE_REM_EN to drive rem_out; otherwise rem_out is tied to zero.
module bm_base_divide
    import bm_divide_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int B2TS = DEF_B2TS
) (
    input  logic            clock,
    input  logic            reset,
    bm_base_divide_if.slave bus
);

    localparam int CW = cnt_width(B2TS);
    localparam logic [CW-1:0] LAST = CW'(B2TS - 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [B2TS-1:0] dvd_q, dvd_d;
    logic [BITS-1:0] dvs_q, dvs_d;
    logic [BITS:0]   prem_q, prem_d;
    logic            dz_pend_q, dz_pend_d;
    logic [B2TS-1:0] quot_q, quot_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            dz_q, dz_d;
`ifdef BM_DIVIDE_REM_EN
    logic [BITS-1:0] rem_q, rem_d;
`endif

    logic [BITS:0]   step_prem;
    logic            step_q;

    bm_divide_step #(.BITS(BITS)) u_step (
        .prem_in  (prem_q),
        .bit_in   (dvd_q[B2TS-1]),
        .divisor  (dvs_q),
        .prem_out (step_prem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        dz_pend_d = 1'b0;
        quot_d    = quot_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        dz_d      = dz_q;
`ifdef BM_DIVIDE_REM_EN
        rem_d     = rem_q;
`endif

        // A zero divisor spends one cycle here instead of iterating, then reports saturated results.
        if (dz_pend_q) begin
            state_d = DONE;
            valid_d = 1'b1;
            dz_d    = 1'b1;
            quot_d  = '1;
`ifdef BM_DIVIDE_REM_EN
            rem_d   = '1;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd_d   = bus.dividend_in;
                        dvs_d   = bus.divisor_in;
                        prem_d  = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        dz_d    = 1'b0;
                        if (bus.divisor_in == '0) begin
                            dz_pend_d = 1'b1;
                            state_d   = IDLE;
                            busy_d    = 1'b0;
                        end else begin
                            state_d = BUSY;
                            busy_d  = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Quotient bits shift in from the bottom as dividend bits leave the top.
                    dvd_d  = {dvd_q[B2TS-2:0], step_q};
                    prem_d = step_prem;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        quot_d  = {dvd_q[B2TS-2:0], step_q};
`ifdef BM_DIVIDE_REM_EN
                        rem_d   = step_prem[BITS-1:0];
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            dz_pend_q <= 1'b0;
            quot_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            dz_q      <= 1'b0;
`ifdef BM_DIVIDE_REM_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            dz_pend_q <= dz_pend_d;
            quot_q    <= quot_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            dz_q      <= dz_d;
`ifdef BM_DIVIDE_REM_EN
            rem_q     <= rem_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.quot_out = quot_q;
    assign bus.div_zero = dz_q;
`ifdef BM_DIVIDE_REM_EN
    assign bus.rem_out  = rem_q;
`else
    assign bus.rem_out  = '0;
`endif

endmodule

// File: doc/bm_base_divide.md
BM_BASE_DIVIDE -- requirements
Module: bm_base_divide

Interface
REQ-001 SHALL have parameter BITS, default 8, divisor/remainder width.
REQ-002 SHALL have parameter B2TS, default 16 (2*BITS), dividend/quotient width.
REQ-003 SHALL have port clock input 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port start input 1: request a division.
REQ-006 SHALL have port dividend_in input B2TS: unsigned dividend, sampled on the accepting edge.
REQ-007 SHALL have port divisor_in input BITS: unsigned divisor, sampled on the accepting edge.
REQ-008 SHALL have port busy output 1: high while iterating.
REQ-009 SHALL have port valid output 1: results valid, held until the next accept or reset.
REQ-010 SHALL have port quot_out output B2TS: quotient.
REQ-011 SHALL have port rem_out output BITS: remainder.
REQ-012 SHALL have port div_zero output 1: last accepted divisor was zero.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on accept, latch operands, clear valid and div_zero, and clear the iteration counter.
REQ-015 SHALL ignore start while in BUSY, with no change to the latched operands.
REQ-016 SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first, with a partial remainder BITS+1 wide.
REQ-017 SHALL complete B2TS iterations in BUSY; valid rises after the B2TS-th edge following the accepting edge (16 cycles at the default widths), and the state becomes DONE.
REQ-018 SHALL guarantee quot_out*divisor + rem_out == dividend and rem_out < divisor for every nonzero divisor.
REQ-019 SHALL, for divisor zero on accept, skip BUSY and enter DONE on the next edge with quot_out all ones, rem_out all ones, div_zero=1, valid=1.
REQ-020 SHALL hold quot_out, rem_out and div_zero stable while valid=1.
REQ-021 SHALL make busy and valid mutually exclusive; both are low in IDLE.
REQ-022 SHALL, when start is accepted in DONE, deassert valid on that edge and begin the new operation (back-to-back division).

Reset
REQ-023 SHALL, on reset assertion at any time including mid-BUSY, immediately force state IDLE and busy=0, valid=0, quot_out=0, rem_out=0, div_zero=0, and clear the counter.
REQ-024 SHALL resume normal acceptance on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with macro BM_DIVIDE_REM_EN defined, compute and drive rem_out per REQ-018/REQ-019.
REQ-026 SHALL, without BM_DIVIDE_REM_EN, keep the rem_out port present but tie it to 0, with the final remainder register omitted; quotient behaviour and latency are unchanged.

Structure
REQ-027 SHALL place the state enumeration, BITS/B2TS defaults and the iteration-count width constant in shared package bm_divide_pkg.
REQ-028 SHALL implement one restoring step (shift, trial subtract, select) as combinational sub-module bm_divide_step, instantiated once.

Verification
REQ-029 SHALL verify: dividend 1000, divisor 7, start one cycle -> after 16 cycles valid=1, quot_out=142, rem_out=6, div_zero=0.
REQ-030 SHALL verify: dividend 65535, divisor 255 -> quot_out=257, rem_out=0; dividend 5, divisor 9 -> quot_out=0, rem_out=5.
REQ-031 SHALL verify: divisor 0, dividend 1234 -> one cycle later valid=1, div_zero=1, quot_out=16'hFFFF, rem_out=8'hFF, busy never high.
REQ-032 SHALL verify: start pulsed with new operands at iteration 5 of 1000/7 -> ignored; result remains 142 r 6.
REQ-033 SHALL verify: reset asserted at iteration 8 -> outputs immediately 0 and state IDLE; a following 200/3 -> 66 r 2.
REQ-034 SHALL verify: build without BM_DIVIDE_REM_EN, 1000/7 -> quot_out=142, rem_out=0, same latency.
